// File: rtl/ste_nfa_engine.sv
// Runtime-programmable homogeneous NFA: an array of STEs with interval matchers,
// programmable adjacency, start type and report enable, plus a backpressured report port.
module ste_nfa_engine #(
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_INTV   = 4,
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned CFG_DW     = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            run_i,
    input  logic                            flush_i,
    input  logic                            sym_valid_i,
    output logic                            sym_ready_o,
    input  logic [SYM_W-1:0]                sym_i,
    input  logic                            cfg_we_i,
    input  logic [$clog2(NUM_STATES)-1:0]   cfg_state_i,
    input  logic [$clog2(NUM_INTV+2)-1:0]   cfg_field_i,
    input  logic [CFG_DW-1:0]               cfg_wdata_i,
    output logic                            cfg_err_o,
    output logic                            rpt_valid_o,
    input  logic                            rpt_ready_i,
    output logic [NUM_STATES-1:0]           rpt_vec_o,
    output logic [IDX_W-1:0]                rpt_idx_o,
    output logic [NUM_STATES-1:0]           active_o
);

    localparam int unsigned ST_W  = $clog2(NUM_STATES);
    localparam int unsigned FLD_W = $clog2(NUM_INTV + 2);

    logic [SYM_W-1:0]      lo_q     [NUM_STATES][NUM_INTV];
    logic [SYM_W-1:0]      hi_q     [NUM_STATES][NUM_INTV];
    logic [NUM_STATES-1:0] adj_q    [NUM_STATES];
    logic [1:0]            stype_q  [NUM_STATES];
    logic [NUM_STATES-1:0] rpt_en_q;

    logic [NUM_STATES-1:0] active_q;
    logic                  sod_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  rpt_valid_q;
    logic [NUM_STATES-1:0] rpt_vec_q;
    logic [IDX_W-1:0]      rpt_idx_q;
    logic                  cfg_err_q;

    logic                  cfg_bad;
    logic                  cfg_ok;
    logic                  sym_fire;
    logic [NUM_STATES-1:0] match;
    logic [NUM_STATES-1:0] en;
    logic [NUM_STATES-1:0] active_nxt;
    logic [NUM_STATES-1:0] rv;

    // Upper write-data bits are don't-care for every field.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_wdata_i;

    assign cfg_bad = run_i
                   | (32'(cfg_field_i) > NUM_INTV + 1)
                   | (32'(cfg_state_i) >= NUM_STATES);
    assign cfg_ok  = cfg_we_i & ~cfg_bad;

    assign sym_ready_o = run_i & ~flush_i & (~rpt_valid_q | rpt_ready_i);
    assign sym_fire    = sym_valid_i & sym_ready_o;

    always_comb begin
        match = '0;
        en    = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            for (int i = 0; i < NUM_INTV; i++) begin
                if (lo_q[s][i] <= sym_i && sym_i <= hi_q[s][i]) begin
                    match[s] = 1'b1;
                end
            end
            // Start type 3 is reserved and behaves like "none".
            en[s] = (|(adj_q[s] & active_q))
                  | ((stype_q[s] == 2'd1) & sod_q)
                  | (stype_q[s] == 2'd2);
        end
        active_nxt = en & match;
        rv         = active_nxt & rpt_en_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                for (int i = 0; i < NUM_INTV; i++) begin
                    lo_q[s][i] <= '1;
                    hi_q[s][i] <= '0;
                end
                adj_q[s]   <= '0;
                stype_q[s] <= '0;
            end
            rpt_en_q <= '0;
        end else if (cfg_ok) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                if (cfg_state_i == ST_W'(s)) begin
                    for (int i = 0; i < NUM_INTV; i++) begin
                        if (cfg_field_i == FLD_W'(i)) begin
                            lo_q[s][i] <= cfg_wdata_i[SYM_W-1:0];
                            hi_q[s][i] <= cfg_wdata_i[2*SYM_W-1:SYM_W];
                        end
                    end
                    if (cfg_field_i == FLD_W'(NUM_INTV)) begin
                        adj_q[s] <= cfg_wdata_i[NUM_STATES-1:0];
                    end
                    if (cfg_field_i == FLD_W'(NUM_INTV + 1)) begin
                        stype_q[s]  <= cfg_wdata_i[1:0];
                        rpt_en_q[s] <= cfg_wdata_i[2];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i & cfg_bad;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= '0;
            sod_q    <= 1'b1;
            idx_q    <= '0;
        end else if (flush_i) begin
            active_q <= '0;
            sod_q    <= 1'b1;
            idx_q    <= '0;
        end else if (sym_fire) begin
            active_q <= active_nxt;
            sod_q    <= 1'b0;
            idx_q    <= idx_q + 1'b1;
        end
    end

    // sym_fire already implies the previous report is gone or leaving, so loading never drops one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_valid_q <= 1'b0;
            rpt_vec_q   <= '0;
            rpt_idx_q   <= '0;
        end else if (flush_i) begin
            rpt_valid_q <= 1'b0;
        end else if (sym_fire && (|rv)) begin
            rpt_valid_q <= 1'b1;
            rpt_vec_q   <= rv;
            rpt_idx_q   <= idx_q;
        end else if (rpt_valid_q && rpt_ready_i) begin
            rpt_valid_q <= 1'b0;
        end
    end

    assign cfg_err_o   = cfg_err_q;
    assign rpt_valid_o = rpt_valid_q;
    assign rpt_vec_o   = rpt_vec_q;
    assign rpt_idx_o   = rpt_idx_q;
    assign active_o    = active_q;

endmodule

// File: tb/tb_ste_nfa_engine.sv
// Bench for ste_nfa_engine: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a set-based reference model of the automaton.
module tb_ste_nfa_engine;

    localparam int NS = 16;
    localparam int SW = 8;
    localparam int NI = 4;
    localparam int IW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, flush, sym_valid, sym_ready, cfg_we, cfg_err;
    logic [SW-1:0] sym;
    logic [3:0]    cfg_state;
    logic [2:0]    cfg_field;
    logic [DW-1:0] cfg_wdata;
    logic          rpt_valid, rpt_ready;
    logic [NS-1:0] rpt_vec, active;
    logic [IW-1:0] rpt_idx;

    ste_nfa_engine #(
        .NUM_STATES(NS), .SYM_W(SW), .NUM_INTV(NI), .IDX_W(IW), .CFG_DW(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .flush_i(flush),
        .sym_valid_i(sym_valid), .sym_ready_o(sym_ready), .sym_i(sym),
        .cfg_we_i(cfg_we), .cfg_state_i(cfg_state), .cfg_field_i(cfg_field),
        .cfg_wdata_i(cfg_wdata), .cfg_err_o(cfg_err),
        .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_vec_o(rpt_vec),
        .rpt_idx_o(rpt_idx), .active_o(active)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int            m_lo [NS][NI];
    int            m_hi [NS][NI];
    logic [NS-1:0] m_adj [NS];
    int            m_type [NS];
    bit            m_rep [NS];
    logic [NS-1:0] m_act;
    bit            m_sod;
    logic [IW-1:0] m_idx;
    bit            m_valid;
    logic [NS-1:0] m_vec;
    logic [IW-1:0] m_ridx;
    bit            m_err;

    // Observed traffic
    int            n_acc;
    int            taken_idx[$];
    logic [NS-1:0] last_vec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void reset_model();
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < NI; i++) begin
                m_lo[s][i] = 255;
                m_hi[s][i] = 0;
            end
            m_adj[s]  = '0;
            m_type[s] = 0;
            m_rep[s]  = 0;
        end
        m_act   = '0;
        m_sod   = 1;
        m_idx   = '0;
        m_valid = 0;
        m_vec   = '0;
        m_ridx  = '0;
        m_err   = 0;
    endfunction

    // One clock: check combinational ready, advance model across the edge, check outputs.
    task automatic cycle();
        bit            m_ready, fire, err_n, hit, enb;
        logic [NS-1:0] na, rv;
        int            v, f, st;
        #1;
        m_ready = run && !flush && (!m_valid || rpt_ready);
        check("sym_ready", sym_ready, m_ready);
        fire = sym_valid && m_ready;
        if (sym_valid && sym_ready) n_acc++;
        if (rpt_valid && rpt_ready) begin
            taken_idx.push_back(int'(rpt_idx));
            last_vec = rpt_vec;
        end
        v  = int'(sym);
        na = '0;
        for (int s = 0; s < NS; s++) begin
            enb = (m_type[s] == 2) || (m_type[s] == 1 && m_sod);
            for (int p = 0; p < NS; p++) if (m_adj[s][p] && m_act[p]) enb = 1;
            hit = 0;
            for (int i = 0; i < NI; i++) if (m_lo[s][i] <= v && v <= m_hi[s][i]) hit = 1;
            na[s] = enb && hit;
            rv[s] = na[s] && m_rep[s];
        end
        f     = int'(cfg_field);
        st    = int'(cfg_state);
        err_n = cfg_we && (run || f > NI + 1 || st >= NS);
        @(posedge clk);
        #1;
        if (cfg_we && !err_n) begin
            if (f < NI) begin
                m_lo[st][f] = int'(cfg_wdata[7:0]);
                m_hi[st][f] = int'(cfg_wdata[15:8]);
            end else if (f == NI) begin
                m_adj[st] = cfg_wdata[NS-1:0];
            end else begin
                m_type[st] = int'(cfg_wdata[1:0]);
                m_rep[st]  = cfg_wdata[2];
            end
        end
        m_err = err_n;
        if (flush) begin
            m_act   = '0;
            m_idx   = '0;
            m_sod   = 1;
            m_valid = 0;
        end else begin
            if (fire && rv != '0) begin
                m_valid = 1;
                m_vec   = rv;
                m_ridx  = m_idx;
            end else if (m_valid && rpt_ready) begin
                m_valid = 0;
            end
            if (fire) begin
                m_act = na;
                m_idx = m_idx + 1;
                m_sod = 0;
            end
        end
        check("rpt_valid", rpt_valid, m_valid);
        check("active", active, m_act);
        check("cfg_err", cfg_err, m_err);
        if (m_valid) begin
            check("rpt_vec", rpt_vec, m_vec);
            check("rpt_idx", rpt_idx, m_ridx);
        end
    endtask

    task automatic cfg_wr(input int s, input int f, input logic [DW-1:0] d);
        run       = 0;
        cfg_we    = 1;
        cfg_state = 4'(s);
        cfg_field = 3'(f);
        cfg_wdata = d;
        cycle();
        cfg_we = 0;
    endtask

    task automatic sym_in(input logic [SW-1:0] v);
        run       = 1;
        sym_valid = 1;
        sym       = v;
        cycle();
        sym_valid = 0;
    endtask

    // Asynchronous reset pulse between clock edges; registered outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 0;
        #1;
        check("rst_rpt_valid", rpt_valid, 0);
        check("rst_rpt_vec", rpt_vec, 0);
        check("rst_rpt_idx", rpt_idx, 0);
        check("rst_active", active, 0);
        check("rst_cfg_err", cfg_err, 0);
        reset_model();
        #2;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; run = 0; flush = 0; sym_valid = 0; sym = '0; cfg_we = 0;
        cfg_state = '0; cfg_field = '0; cfg_wdata = '0; rpt_ready = 1;
        n_acc = 0; last_vec = '0;
        reset_model();
        #12;
        rst_n = 1;
        check("reset_sym_ready", sym_ready, 0);
        check("reset_rpt_valid", rpt_valid, 0);
        check("reset_rpt_vec", rpt_vec, 0);
        check("reset_rpt_idx", rpt_idx, 0);
        check("reset_active", active, 0);
        check("reset_cfg_err", cfg_err, 0);

        // Single STE, start-of-data, [0x10,0x1F], reporting
        cfg_wr(0, 0, 32'h1F10);
        cfg_wr(0, 5, 32'h5);
        taken_idx.delete();
        sym_in(8'h15);
        sym_in(8'h15);
        check("single_active_after2", active, 0);
        repeat (2) cycle();
        check("single_nrpt", taken_idx.size(), 1);
        check("single_vec", last_vec, 16'h0001);
        if (taken_idx.size() > 0) check("single_idx", taken_idx[0], 0);

        // Chain STE0 -> STE1
        do_reset();
        cfg_wr(0, 0, 32'h0F00);
        cfg_wr(0, 5, 32'h1);
        cfg_wr(1, 0, 32'h1F10);
        cfg_wr(1, 4, 32'h1);
        cfg_wr(1, 5, 32'h4);
        taken_idx.delete();
        sym_in(8'h03);
        sym_in(8'h12);
        sym_in(8'h12);
        repeat (2) cycle();
        check("chain_nrpt", taken_idx.size(), 1);
        check("chain_vec", last_vec, 16'h0002);
        if (taken_idx.size() > 0) check("chain_idx", taken_idx[0], 1);

        // Backpressure: all-input STE0 plus start-of-data STE1, both reporting
        do_reset();
        cfg_wr(0, 0, 32'hFF00);
        cfg_wr(0, 5, 32'h6);
        cfg_wr(1, 0, 32'hFF00);
        cfg_wr(1, 5, 32'h5);
        taken_idx.delete();
        n_acc     = 0;
        rpt_ready = 0;
        run       = 1;
        sym_valid = 1;
        sym       = 8'h42;
        repeat (3) cycle();
        check("bp_accepted", n_acc, 1);
        check("bp_ready_low", sym_ready, 0);
        rpt_ready = 1;
        for (int k = 0; k < 20 && n_acc < 4; k++) cycle();
        sym_valid = 0;
        repeat (3) cycle();
        check("bp_nrpt", taken_idx.size(), 4);
        for (int k = 0; k < 4 && k < taken_idx.size(); k++) check("bp_idx_seq", taken_idx[k], k);

        // Flush with a report pending
        rpt_ready = 0;
        sym_in(8'h40);
        flush = 1;
        cycle();
        flush = 0;
        check("flush_rpt_valid", rpt_valid, 0);
        check("flush_active", active, 0);
        taken_idx.delete();
        rpt_ready = 1;
        sym_in(8'h33);
        repeat (2) cycle();
        check("flush_nrpt", taken_idx.size(), 1);
        check("flush_vec", last_vec, 16'h0003);
        if (taken_idx.size() > 0) check("flush_idx", taken_idx[0], 0);

        // Config rejection
        run = 1; cfg_we = 1; cfg_state = 4'd0; cfg_field = 3'd0; cfg_wdata = 32'h1020;
        cycle();
        cfg_we = 0;
        check("err_run", cfg_err, 1);
        taken_idx.delete();
        sym_in(8'h05);
        repeat (2) cycle();
        check("err_run_unchanged", last_vec, 16'h0001);
        cfg_wr(0, 6, 32'h0);
        check("err_field", cfg_err, 1);
        cfg_wr(0, 0, 32'h1020);
        check("lohi_write_ok", cfg_err, 0);
        taken_idx.delete();
        sym_in(8'h10);
        sym_in(8'h15);
        sym_in(8'h20);
        sym_in(8'h18);
        repeat (2) cycle();
        check("lohi_no_match", taken_idx.size(), 0);

        // Async reset mid-stream
        cfg_wr(0, 0, 32'hFF00);
        rpt_ready = 0;
        run = 1; sym_valid = 1; sym = 8'h77;
        repeat (2) cycle();
        do_reset();
        taken_idx.delete();
        rpt_ready = 1;
        repeat (6) cycle();
        sym_valid = 0;
        repeat (2) cycle();
        check("no_rpt_after_rst", taken_idx.size(), 0);

        // Randomized configuration and traffic
        for (int r = 0; r < 8; r++) begin
            run = 0; sym_valid = 0; flush = 0;
            for (int w = 0; w < 14; w++) begin
                int            f, lo, hi;
                logic [DW-1:0] d;
                f = $urandom_range(7);
                if (f < NI) begin
                    lo = $urandom_range(255);
                    hi = ($urandom_range(3) == 0) ? $urandom_range(255)
                                                  : lo + $urandom_range(90);
                    if (hi > 255) hi = 255;
                    d = DW'((hi << 8) | lo);
                end else if (f == NI) begin
                    d = $urandom() & $urandom() & $urandom();
                end else begin
                    d = $urandom();
                end
                cfg_wr($urandom_range(NS - 1), f, d);
            end
            for (int c = 0; c < 120; c++) begin
                run       = ($urandom_range(15) != 0);
                flush     = ($urandom_range(24) == 0);
                sym_valid = ($urandom_range(3) != 0);
                rpt_ready = ($urandom_range(2) != 0);
                sym       = SW'($urandom_range(255));
                cfg_we    = ($urandom_range(20) == 0);
                cfg_state = 4'($urandom_range(NS - 1));
                cfg_field = 3'($urandom_range(7));
                cfg_wdata = $urandom();
                cycle();
            end
            cfg_we = 0; flush = 0; sym_valid = 0; rpt_ready = 1;
            repeat (2) cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
